// File: rtl/arm_run_ctrl.sv
// arm_run_ctrl: run-control and register-watch block for the single-cycle ARM core.
// Produces the core clock-enable for free-run, bounded-cycle and single-step modes.
// It halts on abort, a register-value watchpoint, the cycle budget or counter
// saturation, and it reports the halt cause, sticky watch hits and commit counts.
module arm_run_ctrl #(
   parameter int DATA_W    = 32,
   parameter int RA_W      = 4,
   parameter int NUM_WATCH = 4,
   parameter int CNT_W     = 16
) (
   input  logic                        CLK,
   input  logic                        RESET_N,
   input  logic                        start,
   input  logic [1:0]                  mode,
   input  logic [CNT_W-1:0]            cycle_limit,
   input  logic                        step,
   input  logic                        abort,
   input  logic                        rf_we,
   input  logic [RA_W-1:0]             rf_wa,
   input  logic [DATA_W-1:0]           rf_wd,
   input  logic [NUM_WATCH-1:0]        watch_en,
   input  logic [NUM_WATCH*RA_W-1:0]   watch_addr,
   input  logic [NUM_WATCH*DATA_W-1:0] watch_val,
   output logic                        core_en,
   output logic                        running,
   output logic                        done,
   output logic [2:0]                  halt_cause,
   output logic [NUM_WATCH-1:0]        hit_vec,
   output logic [CNT_W-1:0]            cycle_cnt,
   output logic [CNT_W-1:0]            wr_cnt
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RUN       = 3'd1,
      S_STEP_WAIT = 3'd2,
      S_STEP_EXEC = 3'd3,
      S_HALTED    = 3'd4
   } state_t;

   localparam logic [1:0] M_FREE    = 2'b00;
   localparam logic [1:0] M_BOUNDED = 2'b01;
   localparam logic [1:0] M_STEP    = 2'b10;

   localparam logic [2:0] C_NONE  = 3'd0;
   localparam logic [2:0] C_LIMIT = 3'd1;
   localparam logic [2:0] C_WATCH = 3'd2;
   localparam logic [2:0] C_ABORT = 3'd3;
   localparam logic [2:0] C_SAT   = 3'd4;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t                 state_q, state_d;
   logic [1:0]             mode_q, mode_d;
   logic [CNT_W-1:0]       limit_q, limit_d;
   logic [CNT_W-1:0]       cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
   logic [NUM_WATCH-1:0]   hit_vec_q, hit_vec_d;
   logic [2:0]             halt_cause_q, halt_cause_d;
   // An abort that arrives together with an accepted start is remembered so the
   // run still halts after its first enabled cycle even if abort was a pulse.
   logic                   abort_pend_q, abort_pend_d;

   logic                   core_en_int;
   logic [NUM_WATCH-1:0]   watch_match;
   logic [CNT_W-1:0]       cnt_inc;
   logic                   abort_eff;
   logic [1:0]             mode_norm;

   // Clock-enable is a pure decode of state so an async reset drops it at once.
   assign core_en_int = (state_q == S_RUN) || (state_q == S_STEP_EXEC);

   // Per-entry watch comparators; only live on enabled (committing) cycles.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_WATCH; gi++) begin : g_watch
         assign watch_match[gi] = core_en_int && rf_we && watch_en[gi] &&
                                  (rf_wa == watch_addr[gi*RA_W +: RA_W]) &&
                                  (rf_wd == watch_val[gi*DATA_W +: DATA_W]);
      end
   endgenerate

   assign cnt_inc   = cycle_cnt_q + CNT_ONE;
   assign abort_eff = abort || abort_pend_q;
   // Reserved mode encoding runs as free mode.
   assign mode_norm = (mode == 2'b11) ? M_FREE : mode;

   // Next-state, counter and status update logic.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      limit_d      = limit_q;
      cycle_cnt_d  = cycle_cnt_q;
      wr_cnt_d     = wr_cnt_q;
      hit_vec_d    = hit_vec_q;
      halt_cause_d = halt_cause_q;
      abort_pend_d = abort_pend_q;

      if (core_en_int) begin
         if (cycle_cnt_q != CNT_MAX) cycle_cnt_d = cnt_inc;
         if (rf_we && (wr_cnt_q != CNT_MAX)) wr_cnt_d = wr_cnt_q + CNT_ONE;
         hit_vec_d = hit_vec_q | watch_match;
      end

      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               mode_d       = mode_norm;
               limit_d      = cycle_limit;
               cycle_cnt_d  = '0;
               wr_cnt_d     = '0;
               hit_vec_d    = '0;
               halt_cause_d = C_NONE;
               abort_pend_d = abort;
               if (mode_norm == M_STEP) begin
                  state_d = S_STEP_WAIT;
               end else if ((mode_norm == M_BOUNDED) && (cycle_limit == '0)) begin
                  state_d      = S_HALTED;
                  halt_cause_d = C_LIMIT;
                  abort_pend_d = 1'b0;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN, S_STEP_EXEC: begin
            abort_pend_d = 1'b0;
            if (abort_eff) begin
               state_d      = S_HALTED;
               halt_cause_d = C_ABORT;
            end else if (|watch_match) begin
               state_d      = S_HALTED;
               halt_cause_d = C_WATCH;
            end else if ((mode_q == M_BOUNDED) && (cnt_inc == limit_q)) begin
               state_d      = S_HALTED;
               halt_cause_d = C_LIMIT;
            end else if ((mode_q == M_FREE) && (cnt_inc == CNT_MAX)) begin
               state_d      = S_HALTED;
               halt_cause_d = C_SAT;
            end else if (state_q == S_STEP_EXEC) begin
               state_d = S_STEP_WAIT;
            end
         end
         S_STEP_WAIT: begin
            if (abort_eff) begin
               state_d      = S_HALTED;
               halt_cause_d = C_ABORT;
               abort_pend_d = 1'b0;
            end else if (step) begin
               state_d = S_STEP_EXEC;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and status registers with asynchronous clear.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= S_IDLE;
         mode_q       <= M_FREE;
         limit_q      <= '0;
         cycle_cnt_q  <= '0;
         wr_cnt_q     <= '0;
         hit_vec_q    <= '0;
         halt_cause_q <= C_NONE;
         abort_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         limit_q      <= limit_d;
         cycle_cnt_q  <= cycle_cnt_d;
         wr_cnt_q     <= wr_cnt_d;
         hit_vec_q    <= hit_vec_d;
         halt_cause_q <= halt_cause_d;
         abort_pend_q <= abort_pend_d;
      end
   end

   assign core_en    = core_en_int;
   assign running    = (state_q == S_RUN) || (state_q == S_STEP_WAIT) ||
                       (state_q == S_STEP_EXEC);
   assign done       = (state_q == S_HALTED);
   assign halt_cause = halt_cause_q;
   assign hit_vec    = hit_vec_q;
   assign cycle_cnt  = cycle_cnt_q;
   assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_arm_run_ctrl.sv
// Directed testbench for arm_run_ctrl: one task per scenario, inline checks.
module tb_arm_run_ctrl;
   localparam int DATA_W = 32;
   localparam int RA_W   = 4;
   localparam int NW     = 4;
   localparam int CNT_W  = 16;

   logic                 CLK = 1'b0;
   logic                 RESET_N = 1'b0;
   logic                 start = 1'b0;
   logic [1:0]           mode = 2'b00;
   logic [CNT_W-1:0]     cycle_limit = '0;
   logic                 step = 1'b0;
   logic                 abort = 1'b0;
   logic                 rf_we = 1'b0;
   logic [RA_W-1:0]      rf_wa = '0;
   logic [DATA_W-1:0]    rf_wd = '0;
   logic [NW-1:0]        watch_en = '0;
   logic [NW*RA_W-1:0]   watch_addr = '0;
   logic [NW*DATA_W-1:0] watch_val = '0;
   logic                 core_en, running, done;
   logic [2:0]           halt_cause;
   logic [NW-1:0]        hit_vec;
   logic [CNT_W-1:0]     cycle_cnt, wr_cnt;

   int n_cmp = 0;
   int n_err = 0;

   arm_run_ctrl #(.DATA_W(DATA_W), .RA_W(RA_W), .NUM_WATCH(NW), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .start(start), .mode(mode),
      .cycle_limit(cycle_limit), .step(step), .abort(abort),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .watch_en(watch_en), .watch_addr(watch_addr), .watch_val(watch_val),
      .core_en(core_en), .running(running), .done(done), .halt_cause(halt_cause),
      .hit_vec(hit_vec), .cycle_cnt(cycle_cnt), .wr_cnt(wr_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic launch(input logic [1:0] m, input logic [CNT_W-1:0] lim);
      start = 1'b1; mode = m; cycle_limit = lim;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      repeat (2) tick();
      n_cmp++;
      if ({core_en, running, done, halt_cause, hit_vec, cycle_cnt, wr_cnt} !== '0) begin
         n_err++; $display("FAIL reset_outputs got en=%0b run=%0b done=%0b cause=%0d hit=%b cyc=%0d wr=%0d want all 0",
                           core_en, running, done, halt_cause, hit_vec, cycle_cnt, wr_cnt);
      end
      RESET_N = 1'b1;
      tick();
      n_cmp++;
      if ({core_en, running, done} !== 3'b000) begin
         n_err++; $display("FAIL idle_after_reset got en/run/done=%b want 000", {core_en, running, done});
      end
      $display("reset: done");
   endtask

   task automatic test_bounded();
      int cnt = 0;
      launch(2'b01, 16'd10);
      n_cmp++;
      if (core_en !== 1'b1) begin n_err++; $display("FAIL bnd_first_en got %b want 1", core_en); end
      for (int i = 0; i < 50 && done !== 1'b1; i++) begin
         if (core_en === 1'b1) cnt++;
         tick();
      end
      n_cmp++;
      if (cnt !== 10) begin n_err++; $display("FAIL bnd_en_cycles got %0d want 10", cnt); end
      n_cmp++;
      if ({done, running, halt_cause} !== {1'b1, 1'b0, 3'd1}) begin
         n_err++; $display("FAIL bnd_status got done=%b run=%b cause=%0d want 1 0 1", done, running, halt_cause);
      end
      n_cmp++;
      if (cycle_cnt !== 16'd10) begin n_err++; $display("FAIL bnd_cycle_cnt got %0d want 10", cycle_cnt); end
      $display("bounded: limit=10 en_cycles=%0d cause=%0d", cnt, halt_cause);
   endtask

   task automatic test_watch();
      watch_en = 4'b0001; watch_addr = {12'd0, 4'd3}; watch_val = {96'd0, 32'd7};
      launch(2'b00, 16'd0);
      rf_we = 1'b1; rf_wa = 4'd3; rf_wd = 32'd5;
      tick();
      n_cmp++;
      if ({running, hit_vec, wr_cnt} !== {1'b1, 4'b0000, 16'd1}) begin
         n_err++; $display("FAIL watch_nomatch got run=%b hit=%b wr=%0d want 1 0000 1", running, hit_vec, wr_cnt);
      end
      rf_wd = 32'd7;
      tick();
      rf_we = 1'b0;
      n_cmp++;
      if ({done, core_en, halt_cause, hit_vec} !== {1'b1, 1'b0, 3'd2, 4'b0001}) begin
         n_err++; $display("FAIL watch_halt got done=%b en=%b cause=%0d hit=%b want 1 0 2 0001", done, core_en, halt_cause, hit_vec);
      end
      n_cmp++;
      if ({wr_cnt, cycle_cnt} !== {16'd2, 16'd2}) begin
         n_err++; $display("FAIL watch_counts got wr=%0d cyc=%0d want 2 2", wr_cnt, cycle_cnt);
      end
      // HALTED ignores step and abort and holds all outputs
      step = 1'b1; abort = 1'b1;
      repeat (3) tick();
      step = 1'b0; abort = 1'b0;
      n_cmp++;
      if ({done, halt_cause, cycle_cnt, core_en} !== {1'b1, 3'd2, 16'd2, 1'b0}) begin
         n_err++; $display("FAIL halted_hold got done=%b cause=%0d cyc=%0d en=%b want 1 2 2 0", done, halt_cause, cycle_cnt, core_en);
      end
      watch_en = '0;
      $display("watch: R3==7 cause=%0d hit=%b wr=%0d", halt_cause, hit_vec, wr_cnt);
   endtask

   task automatic test_step();
      int cnt = 0;
      launch(2'b10, 16'd0);
      n_cmp++;
      if ({running, core_en} !== 2'b10) begin n_err++; $display("FAIL step_wait got run/en=%b want 10", {running, core_en}); end
      for (int k = 0; k < 3; k++) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         for (int j = 0; j < 5; j++) begin
            if (core_en === 1'b1) cnt++;
            tick();
         end
      end
      n_cmp++;
      if (cnt !== 3) begin n_err++; $display("FAIL step_pulses got %0d want 3", cnt); end
      n_cmp++;
      if ({cycle_cnt, running, done} !== {16'd3, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL step_state got cyc=%0d run=%b done=%b want 3 1 0", cycle_cnt, running, done);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_cmp++;
      if ({done, halt_cause, cycle_cnt} !== {1'b1, 3'd3, 16'd3}) begin
         n_err++; $display("FAIL step_abort got done=%b cause=%0d cyc=%0d want 1 3 3", done, halt_cause, cycle_cnt);
      end
      $display("step: pulses=%0d cause=%0d", cnt, halt_cause);
   endtask

   task automatic test_abort_watch();
      watch_en = 4'b0101;
      watch_addr = {4'd0, 4'd3, 4'd0, 4'd3};
      watch_val = {32'd0, 32'd7, 32'd0, 32'd7};
      launch(2'b01, 16'd20);
      repeat (2) tick();
      abort = 1'b1; rf_we = 1'b1; rf_wa = 4'd3; rf_wd = 32'd7;
      tick();
      abort = 1'b0; rf_we = 1'b0;
      n_cmp++;
      if ({done, halt_cause, hit_vec} !== {1'b1, 3'd3, 4'b0101}) begin
         n_err++; $display("FAIL abort_watch got done=%b cause=%0d hit=%b want 1 3 0101", done, halt_cause, hit_vec);
      end
      n_cmp++;
      if ({cycle_cnt, wr_cnt} !== {16'd3, 16'd1}) begin
         n_err++; $display("FAIL abort_watch_cnt got cyc=%0d wr=%0d want 3 1", cycle_cnt, wr_cnt);
      end
      watch_en = '0;
      $display("abort+watch: cause=%0d hit=%b", halt_cause, hit_vec);
   endtask

   task automatic test_zero_limit();
      int cnt = 0;
      int en_seen = 0;
      start = 1'b1; mode = 2'b01; cycle_limit = 16'd0;
      @(posedge CLK);
      #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (core_en === 1'b1) en_seen++;
         tick();
      end
      n_cmp++;
      if ({done, halt_cause, hit_vec, cycle_cnt} !== {1'b1, 3'd1, 4'b0000, 16'd0} || en_seen != 0) begin
         n_err++; $display("FAIL zero_limit got done=%b cause=%0d hit=%b cyc=%0d en_seen=%0d want 1 1 0000 0 0",
                           done, halt_cause, hit_vec, cycle_cnt, en_seen);
      end
      launch(2'b01, 16'd4);
      for (int i = 0; i < 50 && done !== 1'b1; i++) begin
         if (core_en === 1'b1) cnt++;
         tick();
      end
      n_cmp++;
      if (cnt !== 4 || cycle_cnt !== 16'd4 || halt_cause !== 3'd1) begin
         n_err++; $display("FAIL limit4 got en=%0d cyc=%0d cause=%0d want 4 4 1", cnt, cycle_cnt, halt_cause);
      end
      $display("zero_limit: then limit=4 en_cycles=%0d", cnt);
   endtask

   task automatic test_abort_with_start();
      start = 1'b1; abort = 1'b1; mode = 2'b00;
      tick();
      start = 1'b0; abort = 1'b0;
      n_cmp++;
      if ({core_en, running} !== 2'b11) begin n_err++; $display("FAIL abort_start_run got en/run=%b want 11", {core_en, running}); end
      tick();
      n_cmp++;
      if ({done, halt_cause, cycle_cnt} !== {1'b1, 3'd3, 16'd1}) begin
         n_err++; $display("FAIL abort_start got done=%b cause=%0d cyc=%0d want 1 3 1", done, halt_cause, cycle_cnt);
      end
      $display("abort_with_start: cause=%0d cyc=%0d", halt_cause, cycle_cnt);
   endtask

   task automatic test_saturate();
      int cnt = 0;
      launch(2'b11, 16'd0);
      for (int i = 0; i < 70000 && done !== 1'b1; i++) begin
         if (core_en === 1'b1) cnt++;
         tick();
      end
      n_cmp++;
      if ({done, halt_cause, cycle_cnt} !== {1'b1, 3'd4, 16'hFFFF} || cnt != 65535) begin
         n_err++; $display("FAIL saturate got done=%b cause=%0d cyc=%0h en=%0d want 1 4 ffff 65535", done, halt_cause, cycle_cnt, cnt);
      end
      $display("saturate: reserved mode en_cycles=%0d cause=%0d", cnt, halt_cause);
   endtask

   task automatic test_back_to_back_and_reset();
      launch(2'b01, 16'd20);
      rf_we = 1'b1; rf_wa = 4'd1; rf_wd = 32'd0;
      repeat (6) tick();
      n_cmp++;
      if ({cycle_cnt, wr_cnt} !== {16'd6, 16'd6}) begin
         n_err++; $display("FAIL midrun_cnt got cyc=%0d wr=%0d want 6 6", cycle_cnt, wr_cnt);
      end
      // start while running must be ignored
      start = 1'b1; mode = 2'b10;
      tick();
      start = 1'b0;
      n_cmp++;
      if ({running, core_en, cycle_cnt} !== {1'b1, 1'b1, 16'd7}) begin
         n_err++; $display("FAIL start_ignored got run=%b en=%b cyc=%0d want 1 1 7", running, core_en, cycle_cnt);
      end
      #2 RESET_N = 1'b0;
      #1;
      rf_we = 1'b0;
      n_cmp++;
      if ({core_en, running, done, cycle_cnt, wr_cnt, hit_vec} !== '0) begin
         n_err++; $display("FAIL async_reset got en=%b run=%b done=%b cyc=%0d wr=%0d hit=%b want all 0",
                           core_en, running, done, cycle_cnt, wr_cnt, hit_vec);
      end
      start = 1'b1; mode = 2'b01; cycle_limit = 16'd5;
      repeat (2) tick();
      n_cmp++;
      if ({core_en, running, done} !== 3'b000) begin
         n_err++; $display("FAIL start_in_reset got en/run/done=%b want 000", {core_en, running, done});
      end
      start = 1'b0;
      RESET_N = 1'b1;
      tick();
      n_cmp++;
      if ({core_en, running, done, cycle_cnt} !== {3'b000, 16'd0}) begin
         n_err++; $display("FAIL idle_after_release got en/run/done=%b cyc=%0d want 000 0", {core_en, running, done}, cycle_cnt);
      end
      $display("reset_mid_run: cleared run=%b", running);
   endtask

   initial begin
      test_reset();
      test_bounded();
      test_watch();
      test_step();
      test_abort_watch();
      test_zero_limit();
      test_abort_with_start();
      test_saturate();
      test_back_to_back_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
